trigger_burst_controller: RTL and testbench

//  Sequences the waveform player from external trigger edges: rising edge on Trig_Ain or falling edge on Trig_Bin.

---
 rtl/afg_trig_pkg.sv | 24 ++
 rtl/trig_edge_detect.sv | 29 ++
 rtl/trigger_burst_controller.sv | 188 ++++++++++++++++++
 tb/tb_trigger_burst_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/afg_trig_pkg.sv
// Shared mode codes and FSM state encodings for the trigger/burst sequencer.
package afg_trig_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_NORMAL = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_CONT   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_PLAY    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_e;

    // Modes in which a trigger outside ARMED counts as missed.
    function automatic logic is_trig_mode(mode_e mode);
        return (mode == MODE_NORMAL) || (mode == MODE_SINGLE);
    endfunction

endpackage

// File: rtl/trig_edge_detect.sv
// A-rise / B-fall trigger detector; emits one registered event per cycle with either edge.
module trig_edge_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic Trig_Ain,
    input  logic Trig_Bin,
    output logic Trig_Evt
);

    logic ain_q;
    logic bin_q;
    logic evt_q;

    // History loads the live pin level during reset so release never looks like an edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ain_q <= Trig_Ain;
            bin_q <= Trig_Bin;
            evt_q <= 1'b0;
        end else begin
            ain_q <= Trig_Ain;
            bin_q <= Trig_Bin;
            evt_q <= (Trig_Ain & ~ain_q) | (~Trig_Bin & bin_q);
        end
    end

    assign Trig_Evt = evt_q;

endmodule

// File: rtl/trigger_burst_controller.sv
// Trigger-driven sequencer for the waveform player: arm, delay, burst of N periods, holdoff.
module trigger_burst_controller
    import afg_trig_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DLY_W  = 16,
    parameter int unsigned MISS_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Trig_Ain,
    input  logic              Trig_Bin,
    input  logic [1:0]        Mode,
    input  logic              Arm,
    input  logic [CNT_W-1:0]  Burst_Len,
    input  logic [DLY_W-1:0]  Trig_Delay,
    input  logic [DLY_W-1:0]  Holdoff,
    input  logic              Play_Done,
    output logic              Play_Start,
    output logic              Armed,
    output logic              Busy,
    output logic [CNT_W-1:0]  Burst_Cnt,
    output logic [MISS_W-1:0] Miss_Cnt
);

    mode_e              mode;
    logic               trig_evt;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [DLY_W-1:0]   hold_q, hold_d;
    logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic [DLY_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               play_start_q, play_start_d;
    logic               cont_q, cont_d;

    logic               latch_cfg;
    logic               enter_play;
    logic               enter_hold;
    logic [CNT_W-1:0]   burst_next;

    assign mode       = mode_e'(Mode);
    assign burst_next = burst_cnt_q + CNT_W'(1);

    trig_edge_detect u_edge (
        .Clock    (Clock),
        .Reset    (Reset),
        .Trig_Ain (Trig_Ain),
        .Trig_Bin (Trig_Bin),
        .Trig_Evt (trig_evt)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hold_d       = hold_q;
        dly_cnt_d    = dly_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        miss_d       = miss_q;
        play_start_d = 1'b0;
        cont_d       = cont_q;
        latch_cfg    = 1'b0;
        enter_play   = 1'b0;
        enter_hold   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mode == MODE_CONT) begin
                    latch_cfg  = 1'b1;
                    enter_play = 1'b1;
                end else if (mode == MODE_NORMAL || (mode == MODE_SINGLE && Arm)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (mode == MODE_CONT) begin
                    latch_cfg  = 1'b1;
                    enter_play = 1'b1;
                end else if (trig_evt) begin
                    latch_cfg = 1'b1;
                    if (Trig_Delay == '0) begin
                        enter_play = 1'b1;
                    end else begin
                        state_d   = ST_DELAY;
                        dly_cnt_d = Trig_Delay - DLY_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (dly_cnt_q == '0) enter_play = 1'b1;
                else                 dly_cnt_d = dly_cnt_q - DLY_W'(1);
            end
            ST_PLAY: begin
                if (Play_Done) begin
                    burst_cnt_d = burst_next;
                    // A continuous run ends only at a period boundary once Mode leaves 11.
                    if (cont_q) begin
                        if (mode == MODE_CONT) play_start_d = 1'b1;
                        else                   enter_hold   = 1'b1;
                    end else if (burst_next == len_q) begin
                        enter_hold = 1'b1;
                    end else begin
                        play_start_d = 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == '0) begin
                    if (mode == MODE_NORMAL) begin
                        state_d = ST_ARMED;
                    end else if (mode == MODE_CONT) begin
                        latch_cfg  = 1'b1;
                        enter_play = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - DLY_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (latch_cfg) begin
            len_d  = (Burst_Len == '0) ? CNT_W'(1) : Burst_Len;
            hold_d = Holdoff;
        end

        if (enter_play) begin
            state_d      = ST_PLAY;
            play_start_d = 1'b1;
            burst_cnt_d  = '0;
            cont_d       = (mode == MODE_CONT);
        end

        if (enter_hold) begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = (hold_q == '0) ? '0 : hold_q - DLY_W'(1);
        end

        // Mode 00 overrides everything: no start, count frozen.
        if (mode == MODE_OFF) begin
            state_d      = ST_IDLE;
            play_start_d = 1'b0;
            burst_cnt_d  = burst_cnt_q;
        end

        if (Arm) begin
            miss_d = '0;
        end else if (trig_evt && state_q != ST_ARMED && is_trig_mode(mode) && miss_q != '1) begin
            miss_d = miss_q + MISS_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            len_q        <= CNT_W'(1);
            hold_q       <= '0;
            dly_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            miss_q       <= '0;
            play_start_q <= 1'b0;
            cont_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            dly_cnt_q    <= dly_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            miss_q       <= miss_d;
            play_start_q <= play_start_d;
            cont_q       <= cont_d;
        end
    end

    assign Play_Start = play_start_q;
    assign Armed      = (state_q == ST_ARMED);
    assign Busy       = (state_q == ST_DELAY) || (state_q == ST_PLAY) || (state_q == ST_HOLDOFF);
    assign Burst_Cnt  = burst_cnt_q;
    assign Miss_Cnt   = miss_q;

endmodule

// File: tb/tb_trigger_burst_controller.sv
// Directed self-checking bench for trigger_burst_controller.
module tb_trigger_burst_controller;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DLY_W  = 16;
    localparam int unsigned MISS_W = 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Trig_Ain;
    logic              Trig_Bin;
    logic [1:0]        Mode;
    logic              Arm;
    logic [CNT_W-1:0]  Burst_Len;
    logic [DLY_W-1:0]  Trig_Delay;
    logic [DLY_W-1:0]  Holdoff;
    logic              Play_Done;
    logic              Play_Start;
    logic              Armed;
    logic              Busy;
    logic [CNT_W-1:0]  Burst_Cnt;
    logic [MISS_W-1:0] Miss_Cnt;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    trigger_burst_controller #(
        .CNT_W  (CNT_W),
        .DLY_W  (DLY_W),
        .MISS_W (MISS_W)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Trig_Ain   (Trig_Ain),
        .Trig_Bin   (Trig_Bin),
        .Mode       (Mode),
        .Arm        (Arm),
        .Burst_Len  (Burst_Len),
        .Trig_Delay (Trig_Delay),
        .Holdoff    (Holdoff),
        .Play_Done  (Play_Done),
        .Play_Start (Play_Start),
        .Armed      (Armed),
        .Busy       (Busy),
        .Burst_Cnt  (Burst_Cnt),
        .Miss_Cnt   (Miss_Cnt)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge Clock);
    endtask

    // Ticks until Play_Start is seen; returns tick count, 0 on timeout.
    task automatic wait_start(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (Play_Start && lat == 0) lat = i;
            if (lat != 0) break;
        end
    endtask

    initial begin
        int lat;
        int n_start;
        int first;
        int since;

        Reset = 1'b1; Trig_Ain = 1'b0; Trig_Bin = 1'b1; Mode = 2'b00; Arm = 1'b0;
        Burst_Len = '0; Trig_Delay = '0; Holdoff = '0; Play_Done = 1'b0;
        repeat (3) tick();
        check("rst_play_start", Play_Start, 0);
        check("rst_armed", Armed, 0);
        check("rst_busy", Busy, 0);
        check("rst_burst_cnt", Burst_Cnt, 0);
        check("rst_miss_cnt", Miss_Cnt, 0);
        Reset = 1'b0;
        tick();

        // Normal mode: delay 3, two periods, holdoff 4
        Mode = 2'b01; Burst_Len = 2; Trig_Delay = 3; Holdoff = 4;
        tick();
        check("norm_armed", Armed, 1);
        Trig_Ain = 1'b1;
        wait_start(lat);
        check("norm_latency", lat, 5);
        check("norm_cnt_clear", Burst_Cnt, 0);
        check("norm_busy", Busy, 1);
        Burst_Len = 5;
        tick();
        check("norm_start_pulse", Play_Start, 0);
        Play_Done = 1'b1; tick(); Play_Done = 1'b0;
        check("norm_restart", Play_Start, 1);
        check("norm_cnt1", Burst_Cnt, 1);
        tick();
        Play_Done = 1'b1; tick(); Play_Done = 1'b0;
        check("norm_final_no_start", Play_Start, 0);
        check("norm_cnt2", Burst_Cnt, 2);
        check("norm_hold_busy", Busy, 1);
        repeat (3) tick();
        check("norm_hold_not_armed", Armed, 0);
        check("norm_hold_busy_end", Busy, 1);
        tick();
        check("norm_rearmed", Armed, 1);
        check("norm_idle_busy", Busy, 0);
        Play_Done = 1'b1; tick(); Play_Done = 1'b0;
        check("done_outside_play", Burst_Cnt, 2);
        Trig_Ain = 1'b0;
        tick();

        // Single mode: unarmed trigger is a miss, armed trigger runs once
        Mode = 2'b00; tick();
        check("off_idle", Armed, 0);
        Mode = 2'b10; repeat (2) tick();
        check("single_unarmed", Armed, 0);
        Trig_Bin = 1'b0; repeat (2) tick();
        check("single_miss", Miss_Cnt, 1);
        check("single_no_busy", Busy, 0);
        Trig_Bin = 1'b1; Arm = 1'b1; tick(); Arm = 1'b0;
        check("single_armed", Armed, 1);
        check("single_arm_clears", Miss_Cnt, 0);
        Burst_Len = 1; Trig_Delay = 0; Holdoff = 0;
        Trig_Bin = 1'b0;
        wait_start(lat);
        check("single_latency", lat, 2);
        Play_Done = 1'b1; tick(); Play_Done = 1'b0;
        check("single_hold_busy", Busy, 1);
        tick();
        check("single_end_busy", Busy, 0);
        check("single_end_armed", Armed, 0);
        check("single_end_cnt", Burst_Cnt, 1);
        Trig_Bin = 1'b1;
        tick();

        // Burst_Len 0 behaves as one period
        Mode = 2'b01; Burst_Len = 0; tick();
        Trig_Ain = 1'b1;
        n_start = 0; first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            Play_Done = 1'b0;
            if (Play_Start) begin
                n_start++;
                if (first == 0) first = i;
            end
            if (i == 4) Play_Done = 1'b1;
        end
        check("len0_first", first, 2);
        check("len0_count", n_start, 1);
        check("len0_cnt", Burst_Cnt, 1);
        check("len0_rearmed", Armed, 1);
        Trig_Ain = 1'b0;

        // Continuous: player reports done 10 cycles after each start
        Mode = 2'b00; tick();
        Mode = 2'b11; Burst_Len = 1;
        n_start = 0; first = 0; since = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            Play_Done = 1'b0;
            if (Play_Start) begin
                if (n_start == 0) first = i;
                else if (n_start <= 3) check("cont_period", since + 1, 11);
                n_start++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (since == 10) Play_Done = 1'b1;
        end
        check("cont_first", first, 1);
        check("cont_starts", n_start, 4);
        Mode = 2'b00;
        n_start = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (Play_Start) n_start++;
        end
        check("cont_abort_starts", n_start, 0);
        check("cont_abort_busy", Busy, 0);

        // Miss counter saturation during a long holdoff
        Mode = 2'b01; Burst_Len = 1; Trig_Delay = 0; Holdoff = 1000;
        tick();
        Arm = 1'b1; tick(); Arm = 1'b0;
        Trig_Ain = 1'b1; repeat (2) tick();
        Play_Done = 1'b1; tick(); Play_Done = 1'b0;
        check("miss_hold_busy", Busy, 1);
        for (int i = 0; i < 300; i++) begin
            Trig_Bin = 1'b0; tick();
            Trig_Bin = 1'b1; tick();
        end
        tick();
        check("miss_saturate", Miss_Cnt, 255);
        check("miss_still_hold", Busy, 1);
        Arm = 1'b1; tick(); Arm = 1'b0;
        check("miss_arm_clear", Miss_Cnt, 0);
        Trig_Bin = 1'b0; tick();
        Arm = 1'b1; tick(); Arm = 1'b0;
        check("miss_arm_wins", Miss_Cnt, 0);
        Trig_Bin = 1'b1;
        Mode = 2'b00; tick();
        check("abort_hold_busy", Busy, 0);
        check("abort_hold_cnt", Burst_Cnt, 1);

        // Reset mid-burst with Ain held high across release
        Mode = 2'b01; Burst_Len = 3; Holdoff = 0; Trig_Ain = 1'b0;
        tick();
        Trig_Ain = 1'b1;
        wait_start(lat);
        check("rst_test_latency", lat, 2);
        Play_Done = 1'b1; Reset = 1'b1; tick(); Play_Done = 1'b0;
        check("midrst_play_start", Play_Start, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_armed", Armed, 0);
        check("midrst_cnt", Burst_Cnt, 0);
        check("midrst_miss", Miss_Cnt, 0);
        Reset = 1'b0;
        n_start = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (Play_Start) n_start++;
        end
        check("rel_no_event", n_start, 0);
        check("rel_armed", Armed, 1);
        check("rel_busy", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
